// File: rtl/display_source_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_source_sequencer_pkg
// Brief    : Shared types, constants and the digit-slice helper
//            for the display source sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package display_source_sequencer_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    // Bit offset of source 'src' inside the packed multi-source bus
    function automatic int unsigned src_lsb(input int unsigned src, input int unsigned digits);
        return src * digits * 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_source_sequencer_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module   : dwell_timer
// Brief    : Modulo-MOD counter with enable, synchronous clear (wins over
//            enable) and a terminal-count pulse on the wrapping cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int MOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int            CW     = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [CW-1:0] c_last = CW'(MOD - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tc = i_en && !i_clr && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/display_source_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : display_source_sequencer
// Brief    : Registered manual/auto-rotate selector feeding the digit
//            decoders. Optional blink blanking when BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module display_source_sequencer
    import display_source_sequencer_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int DIGITS     = 2,
`ifdef BLINK_EN
    parameter int BLINK_HALF = 25_000_000,
`endif
    parameter int DWELL      = 50_000_000,
    parameter int SW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [N_SRC*DIGITS*4-1:0] SrcData,
    input  logic                      Mode,
    input  logic [SW-1:0]             Sel,
    input  logic                      Hold,
`ifdef BLINK_EN
    input  logic [N_SRC-1:0]          BlinkReq,
`endif
    output logic [DIGITS*4-1:0]       Display,
    output logic [SW-1:0]             ActiveSrc,
    output logic                      SrcChange
);

    localparam int          c_dw_bits  = DIGITS * 4;
    localparam logic [SW-1:0] c_last_src = SW'(N_SRC - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [SW-1:0]        r_active;
    logic [SW-1:0]        w_next_active;
    logic [c_dw_bits-1:0] r_display;
    logic [c_dw_bits-1:0] w_src_digits;
    logic [c_dw_bits-1:0] w_disp_next;
    logic                 r_change;
    logic                 w_change;
    logic                 w_dwell_tc;

    // Dwell only counts once already in AUTO, so entering AUTO starts from 0
    dwell_timer #(.MOD(DWELL)) u_dwell (
        .clk   (Clk),
        .rst   (Rst),
        .i_en  (!Hold && Mode && (r_state == ST_AUTO)),
        .i_clr (!Hold && !Mode),
        .o_tc  (w_dwell_tc)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_active = r_active;
        if (!Hold) begin
            w_next_state = Mode ? ST_AUTO : ST_MANUAL;
            if (!Mode) begin
                if (32'(Sel) < N_SRC) begin
                    w_next_active = Sel;
                end
            end else if (w_dwell_tc) begin
                w_next_active = (r_active == c_last_src) ? '0 : r_active + 1'b1;
            end
        end
    end

    assign w_change     = !Hold && (w_next_active != r_active);
    assign w_src_digits = SrcData[src_lsb(32'(r_active), DIGITS) +: c_dw_bits];

`ifdef BLINK_EN
    logic w_blink_tc;
    logic r_blank;

    dwell_timer #(.MOD(BLINK_HALF)) u_blink (
        .clk   (Clk),
        .rst   (Rst),
        .i_en  (!Hold),
        .i_clr (w_change),
        .o_tc  (w_blink_tc)
    );

    // Each newly shown source begins in the visible phase
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_blank <= 1'b0;
        end else if (!Hold) begin
            if (w_change) begin
                r_blank <= 1'b0;
            end else if (w_blink_tc) begin
                r_blank <= ~r_blank;
            end
        end
    end

    assign w_disp_next = (BlinkReq[r_active] && r_blank) ? {DIGITS{BLANK_DIGIT}} : w_src_digits;
`else
    assign w_disp_next = w_src_digits;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= ST_MANUAL;
            r_active  <= '0;
            r_display <= '0;
            r_change  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_active <= w_next_active;
            r_change <= w_change;
            if (!Hold) begin
                r_display <= w_disp_next;
            end
        end
    end

    assign Display   = r_display;
    assign ActiveSrc = r_active;
    assign SrcChange = r_change;

endmodule
`default_nettype wire
